// File: rtl/mod_add_sub_pipe.sv
// mod_add_sub_pipe: two-stage pipelined modular adder/subtractor with valid/ready handshake
module mod_add_sub_pipe #(
    parameter int WIDTH = 14,
    parameter int Q     = 12289
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic [WIDTH-1:0] Diff
);
    localparam logic [WIDTH:0] QX = (WIDTH+1)'(Q);

    logic [WIDTH:0]   s1, d1;
    logic [WIDTH-1:0] s_red, d_red;
    logic             v1, v2, adv1, adv2;

    // Each stage advances when its successor is empty or draining; ready ripples back combinationally
    always_comb begin
        adv2  = !v2 || out_ready;
        adv1  = !v1 || adv2;
        s_red = WIDTH'((s1 >= QX) ? s1 - QX : s1);
        d_red = WIDTH'(d1[WIDTH] ? d1 + QX : d1);
    end

    assign in_ready  = adv1;
    assign out_valid = v2;

    // Stage 1: raw sum and difference, MSB of the difference is the borrow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            s1 <= '0;
            d1 <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1 <= {1'b0, A} + {1'b0, B};
                d1 <= {1'b0, A} - {1'b0, B};
            end
        end
    end

    // Stage 2: single conditional correction by Q brings both results back into range
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            Sum  <= '0;
            Diff <= '0;
        end else if (adv2) begin
            v2   <= v1;
            Sum  <= s_red;
            Diff <= d_red;
        end
    end
endmodule

// File: tb/tb_mod_add_sub_pipe.sv
// tb_mod_add_sub_pipe: randomized and directed checks of the modular add/sub pipeline
module tb_mod_add_sub_pipe;
    localparam int W = 14;
    localparam int Q = 12289;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic in_ready, out_valid;
    logic [W-1:0] Sum, Diff;

    int passed = 0;
    int total = 0;

    logic [2*W-1:0] expq[$];
    logic o_valid, o_fire, i_rdy;
    logic [W-1:0] o_sum, o_diff;
    int n_before;

    mod_add_sub_pipe #(.WIDTH(W), .Q(Q)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Diff(Diff)
    );

    always #5 clk = ~clk;

    // Reference: plain modular arithmetic on integers
    function automatic logic [2*W-1:0] model(input int a, input int b);
        int s, d;
        s = (a + b) % Q;
        d = (a - b + Q) % Q;
        return {W'(s), W'(d)};
    endfunction

    // Drive one cycle at the falling edge, observe handshakes, then let the rising edge commit them
    task automatic cyc(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
        @(negedge clk);
        in_valid = iv;
        A = a;
        B = b;
        out_ready = ordy;
        #1;
        o_valid = out_valid;
        o_fire = out_valid && out_ready;
        o_sum = Sum;
        o_diff = Diff;
        i_rdy = in_ready;
        n_before = expq.size();
        if (in_valid && in_ready) expq.push_back(model(int'(a), int'(b)));
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (Sum !== '0) $display("FAIL reset_sum got %0d want 0", Sum); else passed++;
        total++; if (Diff !== '0) $display("FAIL reset_diff got %0d want 0", Diff); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        int va[6] = '{12000, 5, 12288, 6000, 0, 1};
        int vb[6] = '{500, 7, 12288, 6289, 12288, 2};
        int vs[6] = '{211, 12, 12287, 0, 12288, 3};
        int vd[6] = '{11500, 12287, 0, 12000, 1, 12288};
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, W'(va[i]), W'(vb[i]), 1'b1);
            cyc(1'b0, '0, '0, 1'b1);
            total++; if (o_valid !== 1'b0) $display("FAIL vec%0d_early_valid got %b want 0", i, o_valid); else passed++;
            cyc(1'b0, '0, '0, 1'b1);
            total++; if (o_valid !== 1'b1) $display("FAIL vec%0d_latency got %b want 1", i, o_valid); else passed++;
            total++; if (o_sum !== W'(vs[i])) $display("FAIL vec%0d_sum got %0d want %0d", i, o_sum, vs[i]); else passed++;
            total++; if (o_diff !== W'(vd[i])) $display("FAIL vec%0d_diff got %0d want %0d", i, o_diff, vd[i]); else passed++;
        end
        expq.delete();
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] e;
        int outs = 0;
        int drops = 0;
        for (int i = 0; i < 102; i++) begin
            if (i < 100) cyc(1'b1, W'($urandom_range(0, Q-1)), W'($urandom_range(0, Q-1)), 1'b1);
            else cyc(1'b0, '0, '0, 1'b1);
            if (i < 100 && i_rdy !== 1'b1) drops++;
            if (o_fire) begin
                outs++;
                total++;
                if (expq.size() == 0) $display("FAIL b2b_extra got %0d/%0d want none", o_sum, o_diff);
                else begin
                    e = expq.pop_front();
                    if ({o_sum, o_diff} !== e) $display("FAIL b2b_data got %0d/%0d want %0d/%0d", o_sum, o_diff, e[2*W-1:W], e[W-1:0]);
                    else passed++;
                end
            end
        end
        total++; if (drops != 0) $display("FAIL b2b_in_ready_drops got %0d want 0", drops); else passed++;
        total++; if (outs != 100) $display("FAIL b2b_count got %0d want 100", outs); else passed++;
    endtask

    task automatic test_random_stall();
        logic [2*W-1:0] e;
        logic prev_stall = 1'b0;
        logic [W-1:0] ps = '0;
        logic [W-1:0] pd = '0;
        logic ordy;
        for (int i = 0; i < 320; i++) begin
            ordy = (i >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
            cyc((i < 300) ? 1'($urandom_range(0, 1)) : 1'b0, W'($urandom_range(0, Q-1)), W'($urandom_range(0, Q-1)), ordy);
            total++;
            if (i_rdy !== !(n_before == 2 && !ordy)) $display("FAIL stall_in_ready got %b want %b", i_rdy, !(n_before == 2 && !ordy));
            else passed++;
            if (prev_stall) begin
                total++;
                if (!o_valid || o_sum !== ps || o_diff !== pd) $display("FAIL stall_hold got %b %0d/%0d want 1 %0d/%0d", o_valid, o_sum, o_diff, ps, pd);
                else passed++;
            end
            prev_stall = o_valid && !ordy;
            ps = o_sum;
            pd = o_diff;
            if (o_fire) begin
                total++;
                if (expq.size() == 0) $display("FAIL stall_extra got %0d/%0d want none", o_sum, o_diff);
                else begin
                    e = expq.pop_front();
                    if ({o_sum, o_diff} !== e) $display("FAIL stall_data got %0d/%0d want %0d/%0d", o_sum, o_diff, e[2*W-1:W], e[W-1:0]);
                    else passed++;
                end
            end
        end
        total++; if (expq.size() != 0) $display("FAIL stall_lost got %0d pending want 0", expq.size()); else passed++;
    endtask

    task automatic test_reset_midflight();
        cyc(1'b1, W'(100), W'(200), 1'b0);
        cyc(1'b1, W'(300), W'(400), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", out_valid); else passed++;
        total++; if (Sum !== '0) $display("FAIL rst_mid_sum got %0d want 0", Sum); else passed++;
        total++; if (Diff !== '0) $display("FAIL rst_mid_diff got %0d want 0", Diff); else passed++;
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, '0, 1'b1);
            total++; if (o_valid !== 1'b0) $display("FAIL rst_stale got %b want 0", o_valid); else passed++;
        end
        cyc(1'b1, W'(1), W'(2), 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        total++;
        if (!o_valid || o_sum !== W'(3) || o_diff !== W'(12288)) $display("FAIL rst_next got %b %0d/%0d want 1 3/12288", o_valid, o_sum, o_diff);
        else passed++;
        expq.delete();
    endtask

    task automatic test_stall_hold();
        logic [2*W-1:0] e1, e2;
        e1 = model(7000, 9000);
        e2 = model(42, 12000);
        cyc(1'b1, W'(7000), W'(9000), 1'b0);
        cyc(1'b1, W'(42), W'(12000), 1'b0);
        cyc(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, W'($urandom_range(0, Q-1)), W'($urandom_range(0, Q-1)), 1'b0);
            total++;
            if (!o_valid || {o_sum, o_diff} !== e1 || i_rdy !== 1'b0)
                $display("FAIL hold_cycle%0d got v=%b %0d/%0d rdy=%b want v=1 %0d/%0d rdy=0", i, o_valid, o_sum, o_diff, i_rdy, e1[2*W-1:W], e1[W-1:0]);
            else passed++;
        end
        cyc(1'b0, '0, '0, 1'b1);
        total++;
        if (!o_fire || {o_sum, o_diff} !== e1) $display("FAIL hold_release1 got %b %0d/%0d want 1 %0d/%0d", o_fire, o_sum, o_diff, e1[2*W-1:W], e1[W-1:0]);
        else passed++;
        cyc(1'b0, '0, '0, 1'b1);
        total++;
        if (!o_fire || {o_sum, o_diff} !== e2) $display("FAIL hold_release2 got %b %0d/%0d want 1 %0d/%0d", o_fire, o_sum, o_diff, e2[2*W-1:W], e2[W-1:0]);
        else passed++;
        cyc(1'b0, '0, '0, 1'b1);
        total++; if (o_valid !== 1'b0) $display("FAIL hold_dup got %b want 0", o_valid); else passed++;
        expq.delete();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_random_stall();
        test_reset_midflight();
        test_stall_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
